uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver with 16x oversampling, LSB first, 1 start bit, DBIT data bits, no parity, stop bit.
//   Consumes the sample-tick strobe from the baud-rate mod-M counter
//   (M=27 at 50 MHz gives 16 ticks per bit at ~115.2 kbaud).
//   Delivers each received byte with a one-cycle done strobe to the downstream interface/FIFO.
// PARAMETERS
//   DBIT     8   data bits per frame (5..8)
//   SB_TICK  16  sample ticks in the stop bit (16=1, 24=1.5, 32=2 stop bits)
// PORTS
//   i_clk           in   1     system clock, all logic on rising edge
//   i_reset         in   1     asynchronous, active-low reset (0 = reset)
//   i_rx            in   1     serial line, idle high, asynchronous to i_clk
//   i_s_tick        in   1     1-cycle sample strobe, 16 per bit period
//   o_dout          out  DBIT  last received data word
//   o_rx_done_tick  out  1     1-cycle pulse: o_dout/o_frame_err just updated
//   o_frame_err     out  1     stop bit of the last frame sampled as 0
// BEHAVIOUR
//   Reset (i_reset=0, async): state=IDLE, s=0, n=0, shift reg b=0, o_dout=0,
//     o_rx_done_tick=0, o_frame_err=0, both synchroniser flops and rx_prev = 1.
//   i_rx passes a 2-flop synchroniser -> rx_s (2 clk latency). rx_prev = rx_s delayed 1 clk.
//   Counters: s = 6-bit tick counter, n = $clog2(DBIT)-bit bit counter.
//     s and n advance only on cycles with i_s_tick=1; otherwise they hold.
//   FSM (one transition per clk max):
//     IDLE : falling edge (rx_prev=1 & rx_s=0) -> START, s=0. No tick needed.
//            Line held low does not re-trigger; a new frame needs a high->low edge.
//     START: on tick with s==7 (mid start bit):
//              rx_s==0 -> DATA, s=0, n=0.
//              rx_s==1 -> IDLE, false start, no strobe.
//            Other ticks: s=s+1.
//     DATA : on tick with s==15: s=0, b={rx_s, b[DBIT-1:1]} (LSB first).
//              n==DBIT-1 -> STOP; else n=n+1.
//            Other ticks: s=s+1.
//     STOP : on tick with s==SB_TICK-1: o_dout<=b, o_frame_err<=~rx_s,
//              o_rx_done_tick=1 for exactly that next cycle -> IDLE.
//            Other ticks: s=s+1.
//   Outputs are registered. o_dout and o_frame_err hold until the next done strobe.
//   o_rx_done_tick is asserted for exactly one clk per completed frame.
//   Strobe cycle: the clk after the final stop-bit tick.
//   Frame error: the byte is still delivered with o_frame_err=1; the FSM returns to IDLE.
//   Reset mid-frame: the frame is abandoned, there is no strobe, and outputs take reset values.
//   A falling edge seen in the same cycle as the STOP->IDLE transition is lost. Back-to-back
//     frames start from IDLE. The transmitter must hold the stop bit >= SB_TICK ticks.
//   i_s_tick asserted on consecutive clks is legal; each cycle counts as one tick.
// TESTING
//   Bench drives i_s_tick from mod-M counter (M=27, 50 MHz); bit period = 432 clk.
//   1) Reset low 5 clk: all outputs 0. Send 0x55 with stop=1
//        -> one done pulse, o_dout=0x55, o_frame_err=0.
//   2) Send 0xA3 then 0x0F back-to-back (1 stop bit)
//        -> two done pulses ~4320 clk apart, o_dout=0xA3 then 0x0F, no errors.
//   3) Glitch: i_rx low for 4 ticks (~108 clk), then high
//        -> no done pulse, FSM in IDLE; following frame 0x81 received correctly.
//   4) Send 0xC6 with stop bit 0, then keep line low 3 frames (break)
//        -> exactly one done pulse, o_dout=0xC6, o_frame_err=1.
//        After the line returns high, 0x12 is received with o_frame_err=0.
//   5) Assert i_reset low mid-frame after 3 data bits
//        -> outputs 0 immediately, no done pulse; next frame 0x3C received correctly.
//   6) DBIT=7, SB_TICK=32: send 7'h5A with 2 stop bits
//        -> o_dout=7'h5A; done pulse after 32 stop ticks, not earlier.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, 1 start bit, DBIT data bits, no parity, SB_TICK stop ticks.
// Delivers each frame with a one-cycle done strobe; frame error flags a stop bit sampled low.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err
);

    localparam int unsigned SW = 6;
    localparam int unsigned NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID      = SW'(7);
    localparam logic [SW-1:0] S_BIT_END  = SW'(15);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            sync1_q, sync2_q, rx_prev_q;
    logic            rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser plus one-cycle delay for falling-edge detection; idle-high reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= i_rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Counters only move on sample ticks; IDLE reacts to the edge without waiting for a tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (s_q == S_STOP_END) begin
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_dout         = dout_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand-written glitch, break, reset and 2-stop-bit cases.
// A scoreboard queue per instance holds expected words, popped on each done strobe.
module tb_uart_rx;

    localparam int unsigned CLKS_PER_TICK = 27;
    localparam int unsigned BIT_CLKS      = 16 * CLKS_PER_TICK;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx8   = 1'b1;
    logic        rx7   = 1'b1;
    logic        s_tick;
    logic [7:0]  dout8;
    logic [6:0]  dout7;
    logic        done8, done7, ferr8, ferr7;

    int unsigned     tick_cnt = 0;
    longint unsigned cyc      = 0;
    longint unsigned stop_start = 0;
    int              n_checks = 0;
    int              n_fail   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
        int         idle_after;
    } vec_t;

    exp_t            q8[$];
    exp_t            q7[$];
    longint unsigned pt8[$];
    longint unsigned last_pt7 = 0;
    int              pulses8 = 0;
    int              pulses7 = 0;
    logic            prev_done8 = 1'b0;
    logic            prev_done7 = 1'b0;
    vec_t            vecs[3];

    always #10 clk = ~clk;

    // Mod-27 baud counter: one tick every 27 clocks, 16 ticks per bit.
    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == CLKS_PER_TICK - 1) ? 0 : tick_cnt + 1;
        cyc      <= cyc + 1;
    end
    assign s_tick = (tick_cnt == CLKS_PER_TICK - 1);

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_rx           (rx8),
        .i_s_tick       (s_tick),
        .o_dout         (dout8),
        .o_rx_done_tick (done8),
        .o_frame_err    (ferr8)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_rx           (rx7),
        .i_s_tick       (s_tick),
        .o_dout         (dout7),
        .o_rx_done_tick (done7),
        .o_frame_err    (ferr7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel7, input logic v);
        if (sel7) rx7 = v;
        else      rx8 = v;
    endtask

    task automatic send_frame(input bit sel7, input logic [7:0] data, input int nbits,
                              input logic stop_val, input int stop_clks);
        drive(sel7, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            drive(sel7, data[i]);
            wait_clks(BIT_CLKS);
        end
        stop_start = cyc;
        drive(sel7, stop_val);
        wait_clks(stop_clks);
        drive(sel7, 1'b1);
    endtask

    // Scoreboard monitors: every strobe must be one cycle wide and match the queue head.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            pulses8++;
            pt8.push_back(cyc);
            check("done8_width", 32'(prev_done8), 32'(0));
            check("done8_expected", 32'(q8.size() != 0), 32'(1));
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("sb_dout8", 32'(dout8), 32'(e.data));
                check("sb_ferr8", 32'(ferr8), 32'(e.ferr));
            end
        end
        prev_done8 = done8;
    end

    always @(negedge clk) begin : mon7
        exp_t e;
        if (done7) begin
            pulses7++;
            last_pt7 = cyc;
            check("done7_width", 32'(prev_done7), 32'(0));
            check("done7_expected", 32'(q7.size() != 0), 32'(1));
            if (q7.size() != 0) begin
                e = q7.pop_front();
                check("sb_dout7", 32'(dout7), 32'(e.data[6:0]));
                check("sb_ferr7", 32'(ferr7), 32'(e.ferr));
            end
        end
        prev_done7 = done7;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int              base;
        longint unsigned d;

        vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0, BIT_CLKS};
        vecs[1] = '{8'hA3, 1'b1, 8'hA3, 1'b0, 0};
        vecs[2] = '{8'h0F, 1'b1, 8'h0F, 1'b0, BIT_CLKS};

        rst_n = 1'b0;
        wait_clks(5);
        check("rst_dout8", 32'(dout8), 32'(0));
        check("rst_done8", 32'(done8), 32'(0));
        check("rst_ferr8", 32'(ferr8), 32'(0));
        check("rst_dout7", 32'(dout7), 32'(0));
        check("rst_done7", 32'(done7), 32'(0));
        check("rst_ferr7", 32'(ferr7), 32'(0));
        rst_n = 1'b1;
        wait_clks(10);

        // Single frame, then two back-to-back frames.
        for (int i = 0; i < 3; i++) begin
            q8.push_back('{vecs[i].exp_data, vecs[i].exp_ferr});
            send_frame(1'b0, vecs[i].data, 8, vecs[i].stop, BIT_CLKS);
            check($sformatf("vec%0d_dout", i), 32'(dout8), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), 32'(ferr8), 32'(vecs[i].exp_ferr));
            wait_clks(vecs[i].idle_after);
        end
        check("vec_pulse_count", 32'(pulses8), 32'(3));
        if (pt8.size() >= 3) begin
            d = pt8[2] - pt8[1];
            check("b2b_interval", 32'(d >= 4293 && d <= 4347), 32'(1));
        end

        // Short low glitch is rejected at mid start bit.
        base = pulses8;
        rx8 = 1'b0;
        wait_clks(4 * CLKS_PER_TICK);
        rx8 = 1'b1;
        wait_clks(BIT_CLKS);
        check("glitch_no_pulse", 32'(pulses8), 32'(base));
        q8.push_back('{8'h81, 1'b0});
        send_frame(1'b0, 8'h81, 8, 1'b1, BIT_CLKS);
        check("glitch_next_dout", 32'(dout8), 32'(8'h81));
        wait_clks(BIT_CLKS);

        // Stop bit low followed by a three-frame break: one strobe, frame error set.
        base = pulses8;
        q8.push_back('{8'hC6, 1'b1});
        send_frame(1'b0, 8'hC6, 8, 1'b0, BIT_CLKS * 31);
        check("break_one_pulse", 32'(pulses8 - base), 32'(1));
        check("break_dout", 32'(dout8), 32'(8'hC6));
        check("break_ferr", 32'(ferr8), 32'(1));
        wait_clks(BIT_CLKS);
        q8.push_back('{8'h12, 1'b0});
        send_frame(1'b0, 8'h12, 8, 1'b1, BIT_CLKS);
        check("after_break_dout", 32'(dout8), 32'(8'h12));
        check("after_break_ferr", 32'(ferr8), 32'(0));
        wait_clks(BIT_CLKS);

        // Reset after three data bits abandons the frame.
        base = pulses8;
        rx8 = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx8 = (i % 2 == 0);
            wait_clks(BIT_CLKS);
        end
        rst_n = 1'b0;
        rx8   = 1'b1;
        #1;
        check("midrst_dout", 32'(dout8), 32'(0));
        check("midrst_ferr", 32'(ferr8), 32'(0));
        check("midrst_done", 32'(done8), 32'(0));
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("midrst_no_pulse", 32'(pulses8), 32'(base));
        q8.push_back('{8'h3C, 1'b0});
        send_frame(1'b0, 8'h3C, 8, 1'b1, BIT_CLKS);
        check("midrst_next_dout", 32'(dout8), 32'(8'h3C));
        wait_clks(BIT_CLKS);

        // 7 data bits, two stop bits: strobe lands in the second stop bit.
        base = pulses7;
        q7.push_back('{8'h5A, 1'b0});
        send_frame(1'b1, 8'h5A, 7, 1'b1, 2 * BIT_CLKS);
        check("d7_pulse_count", 32'(pulses7 - base), 32'(1));
        if (pulses7 > base) begin
            d = last_pt7 - stop_start;
            check("d7_stop32_timing", 32'(d > 432 && d <= 864), 32'(1));
        end
        check("d7_dout", 32'(dout7), 32'(7'h5A));
        wait_clks(BIT_CLKS);

        check("q8_drained", 32'(q8.size()), 32'(0));
        check("q7_drained", 32'(q7.size()), 32'(0));
        check("total_pulses8", 32'(pulses8), 32'(7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
